// File: rtl/portal_pkg.sv
// Shared Portal 2D display types and constants: RGB444 colour, key/background/grid
// colours, screen extents and level map size.
package portal_pkg;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t KEY_COLOR  = 12'hF0F;
  localparam rgb444_t BG_COLOR   = 12'h000;
  localparam rgb444_t GRID_COLOR = 12'h444;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned MAP_W = 100;
  localparam int unsigned MAP_H = 100;

endpackage

// File: rtl/map_pixel_pipe_if.sv
// Scan-position, player-position, ROM and colour-output bundle of map_pixel_pipe.
// slave = the pixel pipe, master = the top level / ROMs that surround it.
interface map_pixel_pipe_if;
  import portal_pkg::*;

  logic          pix_en;
  logic [9:0]    col_addr;
  logic [8:0]    row_addr;
  logic [9:0]    player_x;
  logic [8:0]    player_y;
  logic          pos_valid;
  logic [13:0]   map_addr;
  rgb444_t       map_data;
  logic [7:0]    spr_addr;
  rgb444_t       spr_data;
  rgb444_t       pix_data;
  logic          pix_valid;

  modport slave (
    input  pix_en, col_addr, row_addr, player_x, player_y, pos_valid,
    input  map_data, spr_data,
    output map_addr, spr_addr, pix_data, pix_valid
  );

  modport master (
    output pix_en, col_addr, row_addr, player_x, player_y, pos_valid,
    output map_data, spr_data,
    input  map_addr, spr_addr, pix_data, pix_valid
  );

endinterface

// File: rtl/map_pixel_pipe_pos_dbuf.sv
// Player position double buffer: shadow loads on i_load, active copies at frame start.
// At frame start the outputs already show the value being latched, so the whole frame uses it.
module pos_dbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_start,
  input  logic       i_load,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic [9:0] o_x,
  output logic [8:0] o_y
);

  logic [9:0] r_sh_x, r_act_x;
  logic [8:0] r_sh_y, r_act_y;
  logic [9:0] w_next_x;
  logic [8:0] w_next_y;

  // Shadow bypass: a load coinciding with frame start goes straight to active.
  assign w_next_x = i_load ? i_x : r_sh_x;
  assign w_next_y = i_load ? i_y : r_sh_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_act_x <= '0;
      r_act_y <= '0;
    end else begin
      if (i_load) begin
        r_sh_x <= i_x;
        r_sh_y <= i_y;
      end
      if (i_frame_start) begin
        r_act_x <= w_next_x;
        r_act_y <= w_next_y;
      end
    end
  end

  assign o_x = i_frame_start ? w_next_x : r_act_x;
  assign o_y = i_frame_start ? w_next_y : r_act_y;

endmodule

// File: rtl/map_pixel_pipe.sv
// Two-beat pixel pipeline: 4x-upscaled level map with a keyed 16x16 player sprite on top.
// Optional MAP_GRID_EN overlays a grid on map pixels whose col/row low nibble is zero.
module map_pixel_pipe #(
  parameter int unsigned         MAP_W     = portal_pkg::MAP_W,
  parameter int unsigned         MAP_H     = portal_pkg::MAP_H,
  parameter int unsigned         SCALE_SH  = 2,
  parameter int unsigned         SPR_SZ    = 16,
  parameter portal_pkg::rgb444_t KEY_COLOR = portal_pkg::KEY_COLOR,
  parameter portal_pkg::rgb444_t BG_COLOR  = portal_pkg::BG_COLOR
) (
  input  logic             clk,
  input  logic             rst,
  map_pixel_pipe_if.slave  bus
);
  import portal_pkg::*;

  localparam int unsigned MAP_PX_W = MAP_W << SCALE_SH;
  localparam int unsigned MAP_PX_H = MAP_H << SCALE_SH;
  localparam int unsigned SPR_SH   = $clog2(SPR_SZ);

  logic       w_frame_start;
  logic [9:0] w_ax;
  logic [8:0] w_ay;
  logic       w_on_screen, w_in_map, w_in_spr;
  logic [13:0] w_map_idx;
  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic [7:0] w_spr_idx;
  rgb444_t    w_color;

  logic        r_in_map, r_in_spr, r_s1_valid;
  logic [13:0] r_map_addr;
  logic [7:0]  r_spr_addr;
  rgb444_t     r_pix_data;
  logic        r_pix_valid;
`ifdef MAP_GRID_EN
  logic w_grid;
  logic r_grid;
`endif

  assign w_frame_start = bus.pix_en && (bus.col_addr == '0) && (bus.row_addr == '0);

  pos_dbuf u_pos_dbuf (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (w_frame_start),
    .i_load        (bus.pos_valid),
    .i_x           (bus.player_x),
    .i_y           (bus.player_y),
    .o_x           (w_ax),
    .o_y           (w_ay)
  );

  // Stage 1: region tests and ROM addresses from the scan position.
  assign w_on_screen = (32'(bus.col_addr) < SCREEN_W) && (32'(bus.row_addr) < SCREEN_H);
  assign w_in_map    = w_on_screen && (32'(bus.col_addr) < MAP_PX_W) &&
                       (32'(bus.row_addr) < MAP_PX_H);
  assign w_map_idx   = 14'(((32'(bus.row_addr) >> SCALE_SH) * MAP_W) +
                           (32'(bus.col_addr) >> SCALE_SH));

  // Differences are only meaningful once col>=ax / row>=ay, so no wrap is ever accepted.
  assign w_dx      = bus.col_addr - w_ax;
  assign w_dy      = bus.row_addr - w_ay;
  assign w_in_spr  = w_on_screen && (bus.col_addr >= w_ax) && (bus.row_addr >= w_ay) &&
                     (32'(w_dx) < SPR_SZ) && (32'(w_dy) < SPR_SZ);
  assign w_spr_idx = 8'({w_dy[SPR_SH-1:0], w_dx[SPR_SH-1:0]});

`ifdef MAP_GRID_EN
  assign w_grid = w_in_map && ((bus.col_addr[3:0] == '0) || (bus.row_addr[3:0] == '0));
`endif

  // Stage 2: sprite over map over background, ROM data arriving against stage-1 addresses.
  always_comb begin
    w_color = BG_COLOR;
    if (r_in_spr && (bus.spr_data != KEY_COLOR)) begin
      w_color = bus.spr_data;
    end else if (r_in_map) begin
`ifdef MAP_GRID_EN
      w_color = r_grid ? GRID_COLOR : bus.map_data;
`else
      w_color = bus.map_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_map    <= 1'b0;
      r_in_spr    <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_map_addr  <= '0;
      r_spr_addr  <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
`ifdef MAP_GRID_EN
      r_grid      <= 1'b0;
`endif
    end else if (bus.pix_en) begin
      r_in_map    <= w_in_map;
      r_in_spr    <= w_in_spr;
      r_s1_valid  <= 1'b1;
      r_map_addr  <= w_in_map ? w_map_idx : '0;
      r_spr_addr  <= w_in_spr ? w_spr_idx : '0;
      r_pix_data  <= w_color;
      r_pix_valid <= r_s1_valid;
`ifdef MAP_GRID_EN
      r_grid      <= w_grid;
`endif
    end
  end

  assign bus.map_addr  = r_map_addr;
  assign bus.spr_addr  = r_spr_addr;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_valid = r_pix_valid;

endmodule

// File: doc/map_pixel_pipe.md
Name: map_pixel_pipe

Overview:
- Pixel-colour generator feeding vgac's d_in in the Portal 2D top level.
- Converts vgac's row/col scan position into a 12-bit RGB444 colour.
- Looks up the 100x100 level map ROM, upscaled 4x to 400x400 screen pixels, and overlays a 16x16 player sprite.
- Fixed-latency pipeline advancing only on the pixel-clock enable; player position is double-buffered so no frame tears.

Parameters:
- MAP_W, 100, map width in map pixels.
- MAP_H, 100, map height in map pixels.
- SCALE_SH, 2, log2 of screen pixels per map pixel (4x4).
- SPR_SZ, 16, sprite edge length in screen pixels (power of 2).
- KEY_COLOR, 12'hF0F, sprite transparency key.
- BG_COLOR, 12'h000, colour outside the map area.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  one-cycle strobe per VGA pixel (clkdiv[1] rate)
- col_addr  in  10  vgac column (x)
- row_addr  in  9  vgac row (y)
- player_x  in  10  sprite top-left x, screen pixels
- player_y  in  9  sprite top-left y, screen pixels
- pos_valid  in  1  load player_x/y into shadow register
- map_addr  out  14  address to map ROM (combinational spo ROM)
- map_data  in  12  map ROM data
- spr_addr  out  8  address to sprite ROM (combinational spo ROM)
- spr_data  in  12  sprite ROM data
- pix_data  out  12  colour to vgac d_in
- pix_valid  out  1  pix_data corresponds to a position sampled 2 pix_en beats earlier

Behaviour:
- Reset: pix_data=0, pix_valid=0, map_addr=0, spr_addr=0, shadow and active position = 0, pipeline flags cleared.
- Shadow position: loads player_x/y on any cycle with pos_valid=1.
- Active position: copies from shadow when pix_en=1 and row_addr==0 and col_addr==0 (frame start).
- If pos_valid coincides with frame start, the active register takes the new input values (shadow bypass).
- All pipeline registers hold when pix_en=0.
- Stage 1 (pix_en):
  - in_map = col<(MAP_W<<SCALE_SH) && row<(MAP_H<<SCALE_SH).
  - map_addr = (row>>SCALE_SH)*MAP_W + (col>>SCALE_SH), 14-bit; forced 0 when !in_map.
  - in_spr = col-ax in [0,SPR_SZ) and row-ay in [0,SPR_SZ), using unsigned compare with no wrap. col<ax is outside; ax+SPR_SZ beyond 639 simply clips.
  - spr_addr = {(row-ay)[3:0],(col-ax)[3:0]}; 0 when !in_spr.
  - Flags are registered.
- Stage 2 (pix_en): first matching rule wins.
  - in_spr && spr_data!=KEY_COLOR gives spr_data.
  - Otherwise in_map gives map_data.
  - Otherwise BG_COLOR.
  - Result registered into pix_data; pix_valid=1 from the 2nd pix_en after reset onward.
- Latency: exactly 2 pix_en beats; the top level compensates by leading the coordinates.
- Coordinates >=640 or >=480 (blanking) are treated as outside both regions, giving BG_COLOR.
- rst mid-frame: pipeline clears immediately; output resumes after 2 pix_en beats.

Optional Feature:
- MAP_GRID_EN defined: in-map pixels whose col[3:0]==0 or row[3:0]==0 output 12'h444.
  - The grid is evaluated at stage 1 and overrides map_data only; the sprite still wins.
- Undefined: no grid logic, output as above.

Decomposition:
- Shared package portal_pkg holds:
  - RGB444 colour typedef.
  - KEY_COLOR, BG_COLOR and GRID_COLOR constants.
  - Screen extents 640/480.
  - MAP_W/MAP_H.
- One sub-module, pos_dbuf: shadow/active position double buffer with frame-start bypass.

Test Plan:
- rst=1 then 0; pix_en every 4th clk; col=5,row=3; map ROM returns 12'h0AE at addr 1 -> map_addr=1, pix_data=12'h0AE after 2 pix_en beats, pix_valid=1.
- col=450,row=10 -> pix_data=BG_COLOR 12'h000; col=399,row=399 -> map_addr=9999.
- Player at (100,50); col=107,row=53; sprite ROM returns 12'hE12 at addr 0x37 -> pix_data=12'hE12. Same pixel with spr_data=12'hF0F -> map colour shown.
- pos_valid with (200,200) at row=240 -> sprite still drawn at old position until next frame start; then new position. pos_valid at frame start -> new position used that frame.
- Hold pix_en=0 for 20 clk mid-line -> pix_data, map_addr and spr_addr unchanged.
- rst asserted mid-line -> pix_data=0, pix_valid=0 next cycle; valid again after 2 pix_en beats. With MAP_GRID_EN: col=16,row=5 in map -> 12'h444.
